// File: rtl/unpool_grad.sv
// unpool_grad: backward-pass companion of the 2x2 max-pool stage.
// Holds one gradient plus its winner code for each pooled position, then
// streams the SIZE x SIZE pre-pool map in raster order. Each gradient lands
// on its winning location and every other location streams as zero.
module unpool_grad #(
  parameter int unsigned N = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [15:0] wr_grad,
  input  logic [2:0]  wr_his,
  input  logic        start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned Size    = N + N;
  localparam int unsigned Depth   = N * N;
  localparam int unsigned Total   = Size * Size;
  localparam int unsigned AddrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [7:0]  LastK   = 8'(Total - 1);
  localparam logic [3:0]  LastCol = 4'(Size - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e r_state, w_state_nxt;

  // Per-entry storage; grad/his are intentionally left out of reset.
  logic [15:0]      r_grad [Depth];
  logic [2:0]       r_his  [Depth];
  logic [Depth-1:0] r_wflag;

  // Raster position of the beat currently on out_data.
  logic [7:0] r_k, w_k_nxt;
  logic [3:0] r_row, r_col, w_row_nxt, w_col_nxt;

  logic        r_out_valid, w_out_valid_nxt;
  logic [15:0] r_out_data, w_out_data_nxt;
  logic        r_out_last, w_out_last_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_clear_flags;

  logic             w_wr_land;
  logic [AddrW-1:0] w_wr_idx;
  logic             w_accept;

  // Lookup path: the location whose value gets registered on this edge.
  logic [3:0]       w_lk_row, w_lk_col;
  logic [6:0]       w_p_full;
  logic             w_p_ok;
  logic [AddrW-1:0] w_p_idx;
  logic [1:0]       w_q;
  logic             w_byp;
  logic [15:0]      w_ent_grad;
  logic [2:0]       w_ent_his;
  logic             w_ent_flag;
  logic [15:0]      w_lk_data;

  assign w_wr_land = wr_en && (r_state == StIdle) && ({1'b0, wr_addr} < 7'(Depth));
  assign w_wr_idx  = AddrW'(wr_addr);
  assign w_accept  = r_out_valid && out_ready;

  // Next raster position: (0,0) when launching from idle, else one step on.
  always_comb begin
    w_lk_row = 4'd0;
    w_lk_col = 4'd0;
    if (r_state == StStream) begin
      if (r_col == LastCol) begin
        w_lk_row = r_row + 4'd1;
      end else begin
        w_lk_row = r_row;
        w_lk_col = r_col + 4'd1;
      end
    end
  end

  assign w_p_full = 7'(w_lk_row >> 1) * 7'(N) + 7'(w_lk_col >> 1);
  assign w_p_ok   = (w_p_full < 7'(Depth));
  assign w_p_idx  = w_p_ok ? AddrW'(w_p_full) : '0;
  assign w_q      = {w_lk_row[0], w_lk_col[0]};

  // A write landing on the start edge must already be visible to beat 0.
  assign w_byp      = w_wr_land && (w_wr_idx == w_p_idx);
  assign w_ent_grad = w_byp ? wr_grad : r_grad[w_p_idx];
  assign w_ent_his  = w_byp ? wr_his : r_his[w_p_idx];
  assign w_ent_flag = w_byp | r_wflag[w_p_idx];

  // Codes 4..7 can never equal {1'b0, q}, so such windows stay all-zero.
  assign w_lk_data = (w_p_ok && w_ent_flag && (w_ent_his == {1'b0, w_q})) ? w_ent_grad : 16'd0;

  // FSM next state and registered-output next values.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_clear_flags   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt     = StStream;
          w_k_nxt         = 8'd0;
          w_row_nxt       = 4'd0;
          w_col_nxt       = 4'd0;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_lk_data;
          w_out_last_nxt  = (LastK == 8'd0);
          w_busy_nxt      = 1'b1;
        end
      end
      StStream: begin
        if (w_accept) begin
          if (r_k == LastK) begin
            w_state_nxt     = StDone;
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = 16'd0;
            w_out_last_nxt  = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_k_nxt        = r_k + 8'd1;
            w_row_nxt      = w_lk_row;
            w_col_nxt      = w_lk_col;
            w_out_data_nxt = w_lk_data;
            w_out_last_nxt = ((r_k + 8'd1) == LastK);
          end
        end
      end
      StDone: begin
        w_state_nxt   = StIdle;
        w_clear_flags = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Raster counter and output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k         <= 8'd0;
      r_row       <= 4'd0;
      r_col       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'd0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_k         <= w_k_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Written flags: set by a landing write, wiped at frame end or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wflag <= '0;
    end else if (w_clear_flags) begin
      r_wflag <= '0;
    end else if (w_wr_land) begin
      r_wflag[w_wr_idx] <= 1'b1;
    end
  end

  // Gradient and winner-code storage.
  always_ff @(posedge clk) begin
    if (w_wr_land) begin
      r_grad[w_wr_idx] <= wr_grad;
      r_his[w_wr_idx]  <= wr_his;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_unpool_grad.sv
// Scoreboard bench for unpool_grad: the stimulus side scatters the modelled
// entries into an expected map and queues it; a monitor pops on every
// accepted beat and also checks stall stability and the done pulse.
module tb_unpool_grad;

  localparam int N     = 3;
  localparam int SIZE  = 2 * N;
  localparam int DEPTH = N * N;
  localparam int TOTAL = SIZE * SIZE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_grad = '0;
  logic [2:0]  wr_his = '0;
  logic        start = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  unpool_grad #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_grad   (wr_grad),
    .wr_his    (wr_his),
    .start     (start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  // Reference model: pooled entries as plain arrays.
  logic [15:0] m_grad [64];
  logic [2:0]  m_his  [64];
  bit          m_flag [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_write(input int a, input logic [15:0] g, input logic [2:0] h);
    if (a < DEPTH) begin
      m_grad[a] = g;
      m_his[a]  = h;
      m_flag[a] = 1'b1;
    end
  endtask

  // Scatter every written entry to its 2x2 winner, queue the raster frame.
  task automatic push_frame();
    logic [15:0] map [TOTAL];
    beat_t b;
    int r, c;
    for (int k = 0; k < TOTAL; k++) map[k] = 16'd0;
    for (int a = 0; a < DEPTH; a++) begin
      if (m_flag[a] && m_his[a] < 3'd4) begin
        r = 2 * (a / N) + int'(m_his[a][1]);
        c = 2 * (a % N) + int'(m_his[a][0]);
        map[r * SIZE + c] = m_grad[a];
      end
    end
    for (int k = 0; k < TOTAL; k++) begin
      b.data = map[k];
      b.last = (k == TOTAL - 1);
      exp_q.push_back(b);
    end
    for (int a = 0; a < 64; a++) m_flag[a] = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [15:0] g, input logic [2:0] h);
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_grad = g;
    wr_his = h;
    model_write(a, g, h);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(input bit with_wr, input int a, input logic [15:0] g,
                          input logic [2:0] h);
    if (with_wr) begin
      wr_en = 1'b1;
      wr_addr = 6'(a);
      wr_grad = g;
      wr_his = h;
      model_write(a, g, h);
    end
    start = 1'b1;
    push_frame();
    acc_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Wait for done with a cycle budget; optionally spray ignored start pulses.
  task automatic wait_done(input bit spam, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (done) begin
        start = 1'b0;
        break;
      end
      if (cycles > 3000) begin
        start = 1'b0;
        chk("done_timeout", 32'(cycles), 32'd0);
        break;
      end
      start = spam ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    chk("beats_per_frame", 32'(acc_cnt), 32'(TOTAL));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // out_ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_phase++;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: pops on every handshake, checks stalls and the done pulse.
  initial begin
    beat_t e;
    bit exp_done = 1'b0;
    bit stalled = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_done = 1'b0;
        stalled = 1'b0;
      end else begin
        if (exp_done) begin
          chk("done_pulse", {29'd0, done, out_valid, busy}, 32'b100);
          exp_done = 1'b0;
        end else if (done) begin
          chk("spurious_done", 32'(done), 32'd0);
        end
        if (out_valid) begin
          if (stalled) begin
            chk("stall_data_hold", 32'(out_data), 32'(prev_data));
            chk("stall_last_hold", 32'(out_last), 32'(prev_last));
          end
          chk("busy_while_valid", 32'(busy), 32'd1);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 32'(acc_cnt), 32'(TOTAL));
              exp_done = out_last;
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("data_k%0d", acc_cnt), 32'(out_data), 32'(e.data));
              chk($sformatf("last_k%0d", acc_cnt), 32'(out_last), 32'(e.last));
              exp_done = e.last;
            end
            acc_cnt++;
          end
          stalled = !out_ready;
          prev_data = out_data;
          prev_last = out_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int na;
    for (int a = 0; a < 64; a++) m_flag[a] = 1'b0;

    // Reset state.
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    #22 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: full load, ready held high, check one-beat-per-cycle timing.
    rdy_mode = 0;
    for (int a = 0; a < DEPTH; a++) do_write(a, 16'h0100 + 16'(a), 3'(a % 4));
    do_start(1'b0, 0, '0, '0);
    wait_done(1'b0, cyc);
    chk("basic_cycles_to_done", 32'(cyc), 32'(TOTAL + 1));

    // Backpressure with the 1,0,0,1 pattern and ignored start pulses.
    rdy_mode = 1;
    for (int a = 0; a < DEPTH; a++) do_write(a, 16'h0100 + 16'(a), 3'(a % 4));
    do_start(1'b0, 0, '0, '0);
    wait_done(1'b1, cyc);

    // Unwritten entries, out-of-range address, non-matching winner code.
    rdy_mode = 0;
    do_write(4, 16'hBEEF, 3'd3);
    do_write(9, 16'hDEAD, 3'd1);
    do_write(2, 16'h7777, 3'd5);
    do_start(1'b0, 0, '0, '0);
    wait_done(1'b0, cyc);

    // Write colliding with start overwrites the earlier value.
    do_write(0, 16'h5555, 3'd0);
    do_start(1'b1, 0, 16'h1234, 3'd2);
    wait_done(1'b0, cyc);

    // Frame isolation: no writes, flags must be gone.
    rdy_mode = 2;
    do_start(1'b0, 0, '0, '0);
    wait_done(1'b1, cyc);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      rdy_mode = (f % 3);
      na = $urandom_range(0, 12);
      for (int i = 0; i < na; i++) begin
        do_write($urandom_range(0, 11), 16'($urandom), 3'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 1) == 1) begin
        do_start(1'b1, $urandom_range(0, 8), 16'($urandom), 3'($urandom_range(0, 3)));
      end else begin
        do_start(1'b0, 0, '0, '0);
      end
      wait_done(1'b1, cyc);
    end

    // Reset during beat 10.
    rdy_mode = 0;
    for (int a = 0; a < DEPTH; a++) do_write(a, 16'hA000 + 16'(a), 3'((a + 1) % 4));
    do_start(1'b0, 0, '0, '0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt >= 10) break;
    end
    chk("beats_before_reset", 32'(acc_cnt), 32'd10);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    for (int a = 0; a < 64; a++) m_flag[a] = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(1'b0, 0, '0, '0);
    wait_done(1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
